// File: rtl/fifo_chk_pkg.sv
// Shared types for the FIFO scoreboard checker. FIFO_CHK_XPROP_EN adds the XPROP
// error code and widens the error vector to 8 bits.
package fifo_chk_pkg;

`ifdef FIFO_CHK_XPROP_EN
  localparam int NUM_ERR = 8;
`else
  localparam int NUM_ERR = 7;
`endif

  typedef enum logic [2:0] {
    FULL_MISMATCH     = 3'd0,
    EMPTY_MISMATCH    = 3'd1,
    AF_MISMATCH       = 3'd2,
    AE_MISMATCH       = 3'd3,
    DATA_MISMATCH     = 3'd4,
    OVERFLOW_ATTEMPT  = 3'd5,
    UNDERFLOW_ATTEMPT = 3'd6,
    XPROP             = 3'd7
  } err_code_e;

  typedef enum logic [1:0] {WARM, RUN, HALT} fsm_state_e;

  function automatic logic [2:0] lowest_err(input logic [NUM_ERR-1:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = NUM_ERR - 1; i >= 0; i--)
      if (v[i]) r = 3'(i);
    return r;
  endfunction

endpackage

// File: rtl/fifo_chk_shadow_mem.sv
// Shadow copy of the watched FIFO: data store, wrap-around pointers and the
// read-latency expect pipe that lines stored data up with the DUT read_data.
module fifo_chk_shadow_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  adv,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  exp_valid,
  output logic [DATA_WIDTH-1:0] exp_data
);
  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;

  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= write_data;

  // Pointers are PW bits wide, so the increment wraps modulo DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  generate
    if (RD_LATENCY == 0) begin : g_comb
      assign exp_valid = rd;
      assign exp_data  = mem[rd_ptr];
    end else begin : g_pipe
      logic [RD_LATENCY-1:0]                 vld_pipe;
      logic [RD_LATENCY-1:0][DATA_WIDTH-1:0] dat_pipe;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld_pipe <= '0;
          dat_pipe <= '0;
        end else if (adv) begin
          vld_pipe[0] <= rd;
          dat_pipe[0] <= mem[rd_ptr];
          for (int i = 1; i < RD_LATENCY; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            dat_pipe[i] <= dat_pipe[i-1];
          end
        end
      end
      assign exp_valid = vld_pipe[RD_LATENCY-1];
      assign exp_data  = dat_pipe[RD_LATENCY-1];
    end
  endgenerate

endmodule

// File: rtl/fifo_scoreboard_checker.sv
// Pin-level checker for a synchronous FIFO: shadow occupancy/data model, flag and
// data checks, sticky error reporting. FIFO_CHK_XPROP_EN enables X/Z input checks.
module fifo_scoreboard_checker
  import fifo_chk_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int RD_LATENCY  = 1,
  parameter int AF_THRESH   = DEPTH - 2,
  parameter int AE_THRESH   = 2,
  parameter int WARMUP      = 7,
  parameter int STOP_ON_ERR = 0,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       write_en,
  input  logic                       read_en,
  input  logic [DATA_WIDTH-1:0]      write_data,
  input  logic [DATA_WIDTH-1:0]      read_data,
  input  logic                       write_full,
  input  logic                       read_empty,
  input  logic                       almost_full,
  input  logic                       almost_empty,
  output logic                       chk_active,
  output logic                       err_pulse,
  output logic [NUM_ERR-1:0]         err_vec,
  output logic [2:0]                 first_err,
  output logic [CNT_WIDTH-1:0]       err_count,
  output logic [$clog2(DEPTH):0]     model_count
);
  localparam int          CW = $clog2(DEPTH) + 1;
  localparam logic [31:0] WU = WARMUP;

  fsm_state_e            state;
  logic [31:0]           warm_cnt;
  logic                  wr_acc, rd_acc, x_in, adv, upd;
  logic                  exp_valid;
  logic [DATA_WIDTH-1:0] exp_data;
  logic [NUM_ERR-1:0]    errs;

`ifdef FIFO_CHK_XPROP_EN
  assign x_in = $isunknown({write_en, read_en, write_data, read_data,
                            write_full, read_empty, almost_full, almost_empty});
`else
  assign x_in = 1'b0;
`endif

  assign wr_acc = write_en && !write_full;
  assign rd_acc = read_en && !read_empty;
  assign adv    = (state != HALT);
  assign upd    = adv && !x_in;

  fifo_chk_shadow_mem #(
    .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .RD_LATENCY(RD_LATENCY)
  ) u_shadow (
    .clk(clk), .rst(rst), .adv(adv),
    .wr(upd && wr_acc), .rd(upd && rd_acc),
    .write_data(write_data), .exp_valid(exp_valid), .exp_data(exp_data)
  );

  always_comb begin
    errs = '0;
    if (state == RUN) begin
`ifdef FIFO_CHK_XPROP_EN
      if (x_in) errs[XPROP] = 1'b1;
      else begin
`else
      begin
`endif
        errs[FULL_MISMATCH]     = write_full   != (model_count == CW'(DEPTH));
        errs[EMPTY_MISMATCH]    = read_empty   != (model_count == '0);
        errs[AF_MISMATCH]       = almost_full  != (model_count >= CW'(AF_THRESH));
        errs[AE_MISMATCH]       = almost_empty != (model_count <= CW'(AE_THRESH));
        errs[DATA_MISMATCH]     = exp_valid && (read_data != exp_data);
        errs[OVERFLOW_ATTEMPT]  = write_en && write_full;
        errs[UNDERFLOW_ATTEMPT] = read_en && read_empty;
      end
    end
  end

  // Saturate rather than wrap if the DUT flags let the model run past its bounds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) model_count <= '0;
    else if (upd) begin
      if (wr_acc && !rd_acc && model_count != CW'(DEPTH))
        model_count <= model_count + 1'b1;
      else if (rd_acc && !wr_acc && model_count != '0)
        model_count <= model_count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= WARM;
      warm_cnt   <= '0;
      chk_active <= 1'b0;
      err_pulse  <= 1'b0;
      err_vec    <= '0;
      first_err  <= '0;
      err_count  <= '0;
    end else begin
      case (state)
        WARM: begin
          err_pulse <= 1'b0;
          if (warm_cnt + 32'd1 >= WU) begin
            state      <= RUN;
            chk_active <= 1'b1;
          end else warm_cnt <= warm_cnt + 32'd1;
        end
        RUN: begin
          err_pulse <= |errs;
          if (|errs) begin
            err_vec <= err_vec | errs;
            if (err_vec == '0) first_err <= lowest_err(errs);
            if (err_count != '1) err_count <= err_count + 1'b1;
            if (STOP_ON_ERR != 0) begin
              state      <= HALT;
              chk_active <= 1'b0;
            end
          end
        end
        default: err_pulse <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_scoreboard_checker.sv
// Directed bench: a small behavioural FIFO drives two checkers (STOP_ON_ERR 0 and 1)
// with injectable faults; expected checker outputs are hand-computed constants.
module tb_fifo_scoreboard_checker;
  import fifo_chk_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic write_en = 1'b0, read_en = 1'b0;
  logic [7:0] write_data = 8'h00;
  logic [7:0] read_data;
  logic write_full, read_empty, almost_full, almost_empty;

  logic               a_act, a_pulse, b_act, b_pulse;
  logic [NUM_ERR-1:0] a_vec, b_vec;
  logic [2:0]         a_first, b_first;
  logic [15:0]        a_cnt, b_cnt;
  logic [4:0]         a_mc, b_mc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Behavioural FIFO (depth 16, 1-cycle read latency) with fault knobs.
  int         f_cnt, rd_num;
  int         corrupt_at = -1;
  logic       force_empty = 1'b0;
  logic [7:0] f_mem [16];
  logic [3:0] f_wp, f_rp;

  assign write_full   = (f_cnt == 16);
  assign read_empty   = (f_cnt == 0) || force_empty;
  assign almost_full  = (f_cnt >= 14);
  assign almost_empty = (f_cnt <= 2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_cnt <= 0; rd_num <= 0; f_wp <= '0; f_rp <= '0; read_data <= '0;
    end else begin
      if (write_en && !write_full) begin
        f_mem[f_wp] <= write_data;
        f_wp <= f_wp + 4'd1;
      end
      if (read_en && !read_empty) begin
        read_data <= (rd_num == corrupt_at) ? 8'hAA : f_mem[f_rp];
        f_rp <= f_rp + 4'd1;
        rd_num <= rd_num + 1;
      end
      f_cnt <= f_cnt + int'(write_en && !write_full) - int'(read_en && !read_empty);
    end
  end

  fifo_scoreboard_checker #(.STOP_ON_ERR(0)) u_a (
    .clk(clk), .rst(rst), .write_en(write_en), .read_en(read_en),
    .write_data(write_data), .read_data(read_data), .write_full(write_full),
    .read_empty(read_empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .chk_active(a_act), .err_pulse(a_pulse), .err_vec(a_vec), .first_err(a_first),
    .err_count(a_cnt), .model_count(a_mc));

  fifo_scoreboard_checker #(.STOP_ON_ERR(1)) u_b (
    .clk(clk), .rst(rst), .write_en(write_en), .read_en(read_en),
    .write_data(write_data), .read_data(read_data), .write_full(write_full),
    .read_empty(read_empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .chk_active(b_act), .err_pulse(b_pulse), .err_vec(b_vec), .first_err(b_first),
    .err_count(b_cnt), .model_count(b_mc));

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    step();
    write_en = 1'b0; read_en = 1'b0; force_empty = 1'b0; corrupt_at = -1;
    rst = 1'b0; #2; rst = 1'b1;
    repeat (7) step();
  endtask

  task automatic test_reset();
    #12;
    checks++; if (a_act !== 1'b0)   begin errors++; $display("FAIL rst_act got %0h want 0", a_act); end
    checks++; if (a_vec !== '0)     begin errors++; $display("FAIL rst_vec got %0h want 0", a_vec); end
    checks++; if (a_cnt !== '0)     begin errors++; $display("FAIL rst_cnt got %0h want 0", a_cnt); end
    checks++; if (a_mc !== '0)      begin errors++; $display("FAIL rst_mc got %0h want 0", a_mc); end
    @(posedge clk); #1; rst = 1'b1;
    repeat (6) step();
    checks++; if (a_act !== 1'b0)   begin errors++; $display("FAIL warm6_act got %0h want 0", a_act); end
    step();
    checks++; if (a_act !== 1'b1)   begin errors++; $display("FAIL warm7_act got %0h want 1", a_act); end
    step();
    checks++; if (a_vec !== '0)     begin errors++; $display("FAIL idle_vec got %0h want 0", a_vec); end
    checks++; if (a_mc !== 5'd0)    begin errors++; $display("FAIL idle_mc got %0d want 0", a_mc); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 16; i++) begin
      write_en = 1'b1; write_data = 8'(i);
      step();
    end
    write_en = 1'b0;
    step();
    checks++; if (a_mc !== 5'd16)   begin errors++; $display("FAIL fill_mc got %0d want 16", a_mc); end
    checks++; if (a_vec !== '0)     begin errors++; $display("FAIL fill_vec got %0h want 0", a_vec); end
    write_en = 1'b1; write_data = 8'hEE;
    step();
    write_en = 1'b0;
    checks++; if (a_vec !== 7'h20)  begin errors++; $display("FAIL ovf_vec got %0h want 20", a_vec); end
    checks++; if (a_cnt !== 16'd1)  begin errors++; $display("FAIL ovf_cnt got %0d want 1", a_cnt); end
    checks++; if (a_first !== 3'd5) begin errors++; $display("FAIL ovf_first got %0d want 5", a_first); end
    checks++; if (a_pulse !== 1'b1) begin errors++; $display("FAIL ovf_pulse got %0h want 1", a_pulse); end
    step();
    checks++; if (a_pulse !== 1'b0) begin errors++; $display("FAIL ovf_pulse_end got %0h want 0", a_pulse); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      read_en = 1'b1;
      step();
      checks++; if (a_pulse !== 1'b0) begin errors++; $display("FAIL drain_pulse[%0d] got %0h want 0", i, a_pulse); end
    end
    read_en = 1'b0;
    step();
    checks++; if (a_mc !== 5'd0)    begin errors++; $display("FAIL drain_mc got %0d want 0", a_mc); end
    checks++; if (a_cnt !== 16'd1)  begin errors++; $display("FAIL drain_cnt got %0d want 1", a_cnt); end
    checks++; if (a_vec !== 7'h20)  begin errors++; $display("FAIL drain_vec got %0h want 20", a_vec); end
  endtask

  task automatic test_corrupt();
    int pulses = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      write_en = 1'b1; write_data = 8'h30 + 8'(i);
      step();
    end
    write_en = 1'b0; corrupt_at = 2;
    for (int i = 0; i < 6; i++) begin
      read_en = (i < 4);
      step();
      if (a_pulse === 1'b1) pulses++;
    end
    read_en = 1'b0; corrupt_at = -1;
    checks++; if (pulses !== 1)     begin errors++; $display("FAIL corrupt_pulses got %0d want 1", pulses); end
    checks++; if (a_vec !== 7'h10)  begin errors++; $display("FAIL corrupt_vec got %0h want 10", a_vec); end
    checks++; if (a_first !== 3'd4) begin errors++; $display("FAIL corrupt_first got %0d want 4", a_first); end
    checks++; if (a_cnt !== 16'd1)  begin errors++; $display("FAIL corrupt_cnt got %0d want 1", a_cnt); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      write_en = 1'b1; write_data = 8'h50 + 8'(i);
      step();
    end
    read_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      write_data = 8'h60 + 8'(i);
      step();
      checks++; if (a_mc !== 5'd8) begin errors++; $display("FAIL b2b_mc[%0d] got %0d want 8", i, a_mc); end
    end
    write_en = 1'b0; read_en = 1'b0;
    step(); step();
    checks++; if (a_cnt !== 16'd1)  begin errors++; $display("FAIL b2b_cnt got %0d want 1", a_cnt); end
    checks++; if (a_vec !== 7'h10)  begin errors++; $display("FAIL b2b_vec got %0h want 10", a_vec); end
  endtask

  task automatic test_halt();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      write_en = 1'b1; write_data = 8'h70 + 8'(i);
      step();
    end
    write_en = 1'b0; force_empty = 1'b1;
    step();
    checks++; if (b_vec !== 7'h02)  begin errors++; $display("FAIL halt_vec got %0h want 02", b_vec); end
    checks++; if (b_first !== 3'd1) begin errors++; $display("FAIL halt_first got %0d want 1", b_first); end
    checks++; if (b_cnt !== 16'd1)  begin errors++; $display("FAIL halt_cnt got %0d want 1", b_cnt); end
    checks++; if (b_act !== 1'b0)   begin errors++; $display("FAIL halt_act got %0h want 0", b_act); end
    checks++; if (b_pulse !== 1'b1) begin errors++; $display("FAIL halt_pulse got %0h want 1", b_pulse); end
    write_en = 1'b1; write_data = 8'h99;
    step();
    write_en = 1'b0;
    step(); step();
    checks++; if (b_cnt !== 16'd1)  begin errors++; $display("FAIL halt_frozen_cnt got %0d want 1", b_cnt); end
    checks++; if (b_mc !== 5'd5)    begin errors++; $display("FAIL halt_frozen_mc got %0d want 5", b_mc); end
    checks++; if (b_pulse !== 1'b0) begin errors++; $display("FAIL halt_pulse_end got %0h want 0", b_pulse); end
    checks++; if (a_cnt !== 16'd4)  begin errors++; $display("FAIL run_cnt got %0d want 4", a_cnt); end
    checks++; if (a_mc !== 5'd6)    begin errors++; $display("FAIL run_mc got %0d want 6", a_mc); end
    force_empty = 1'b0;
    rst = 1'b0; #1;
    checks++; if (b_act !== 1'b0)   begin errors++; $display("FAIL rst2_act got %0h want 0", b_act); end
    checks++; if (b_pulse !== 1'b0) begin errors++; $display("FAIL rst2_pulse got %0h want 0", b_pulse); end
    checks++; if (b_vec !== '0)     begin errors++; $display("FAIL rst2_vec got %0h want 0", b_vec); end
    checks++; if (b_first !== '0)   begin errors++; $display("FAIL rst2_first got %0h want 0", b_first); end
    checks++; if (b_cnt !== '0)     begin errors++; $display("FAIL rst2_cnt got %0h want 0", b_cnt); end
    checks++; if (b_mc !== '0)      begin errors++; $display("FAIL rst2_mc got %0h want 0", b_mc); end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_drain();
    test_corrupt();
    test_back_to_back();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
